// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates NUM_REQ writeback sources onto
// the single write port (we3/a3/wd3, registered, 1-cycle latency), keeps a
// 32-entry busy scoreboard and flags RAW hazards on two decode read addresses.
// Optional build macro RF_WB_RR_EN selects round-robin arbitration; without it
// the arbiter is fixed priority (index 0 highest) and no rr register exists.
module rf_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int RR_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [5*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  rsv_valid,
  input  logic [4:0]            rsv_addr,
  output logic                  rsv_ready,
  input  logic [4:0]            chk_a1,
  input  logic [4:0]            chk_a2,
  output logic                  hz1,
  output logic                  hz2,
  output logic [31:0]           busy,
  output logic                  we3,
  output logic [4:0]            a3,
  output logic [31:0]           wd3
);

  logic [NUM_REQ-1:0][4:0]  addr_a;
  logic [NUM_REQ-1:0][31:0] data_a;
  assign addr_a = req_addr;
  assign data_a = req_data;

  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic [RR_W-1:0]    gidx;
  logic [4:0]         sel_addr;
  logic [31:0]        sel_data;
  logic [31:0]        busy_q, busy_nxt;
  logic               rsv_set;
  int                 idx;

`ifdef RF_WB_RR_EN
  logic [RR_W-1:0] rr;

  // Round-robin pointer: moves one past the last winner, holds when idle.
  always_ff @(posedge clk) begin
    if (reset)      rr <= '0;
    else if (found) rr <= (gidx == RR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
  end
`endif

  // Arbiter: first valid requester from the search start wins; nothing during reset.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RF_WB_RR_EN
      idx = (int'(rr) + k) % NUM_REQ;
`else
      idx = k;
`endif
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = RR_W'(idx);
      end
    end
    if (reset) found = 1'b0;
    gnt = '0;
    if (found) gnt[gidx] = 1'b1;
  end

  assign req_ready = gnt;

  // One-hot mux of the winner's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = addr_a[k];
        sel_data = data_a[k];
      end
    end
  end

  // A reservation may proceed if the register is free or is being freed now.
  assign rsv_ready = !reset && (!busy_q[rsv_addr] || (found && sel_addr == rsv_addr));
  assign rsv_set   = rsv_valid && rsv_ready && (rsv_addr != 5'd0);

  // Scoreboard next state: clear on grant, then set, so set wins on collision.
  always_comb begin
    busy_nxt = busy_q;
    if (found)   busy_nxt[sel_addr] = 1'b0;
    if (rsv_set) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign busy = busy_q;

  // Write port register; x0 writes are accepted but never reach the RF.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= found && (sel_addr != 5'd0);
      if (found && sel_addr != 5'd0) begin
        a3  <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end

  // Hazard: outstanding and not being granted now, or being written this cycle
  // (the RF still returns old data while we3 is high).
  assign hz1 = (chk_a1 != 5'd0) &&
               ((busy_q[chk_a1] && !(found && sel_addr == chk_a1)) ||
                (we3 && a3 == chk_a1));
  assign hz2 = (chk_a2 != 5'd0) &&
               ((busy_q[chk_a2] && !(found && sel_addr == chk_a2)) ||
                (we3 && a3 == chk_a2));

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port (we3/a3/wd3) among NUM_REQ writeback sources, e.g. ALU, load unit and CSR unit.
- Keeps a 32-entry busy scoreboard of destination registers with writes outstanding.
- Flags read-after-write hazards on the two read addresses so the issue stage can stall.
- Sits between the execute/memory units and the register file; its registered outputs drive the register file's write port directly.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8); index 0 is highest fixed priority.
- RR_W, 3, width of the round-robin pointer; must satisfy 2**RR_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  5*NUM_REQ  packed destination register; requester i uses bits [5i+4:5i].
- req_data  in  32*NUM_REQ  packed write data; requester i uses bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant, combinational; a transfer occurs when valid&ready.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_addr  in  5  register being reserved.
- rsv_ready  out  1  reservation accepted this cycle.
- chk_a1  in  5  read address 1 from decode.
- chk_a2  in  5  read address 2 from decode.
- hz1  out  1  chk_a1 has a write outstanding.
- hz2  out  1  chk_a2 has a write outstanding.
- busy  out  32  scoreboard state; bit 0 is always 0.
- we3  out  1  registered write enable to the register file.
- a3  out  5  registered write address.
- wd3  out  32  registered write data.

Behaviour:
- Reset (reset=1 at an edge): we3=0, a3=0, wd3=0, busy=0, rr pointer=0. Any in-flight request is dropped; requesters must re-present after reset.
- While reset=1, req_ready=0 and rsv_ready=0.
- Arbitration runs every cycle over req_valid. At most one req_ready bit is high, and only when the matching req_valid is high. Default policy is fixed priority: lowest index wins.
- A requester holds valid/addr/data stable until it sees ready; ready never depends on that requester's own ready in earlier cycles.
- Write latency is exactly 1 cycle: a grant at edge N gives we3=1, a3=req_addr[g], wd3=req_data[g] after edge N.
- With no grant, we3=0 in the next cycle; a3/wd3 hold their previous values.
- One write is issued per cycle, giving full throughput.
- Writes to x0: accepted (req_ready=1), but we3 stays 0 for that slot; busy[0] is never set.
- Scoreboard set: rsv_valid & rsv_ready & rsv_addr!=0 sets busy[rsv_addr] at the edge.
- rsv_ready = !busy[rsv_addr] | (clear of rsv_addr this cycle). This stalls WAW.
- rsv_addr=0 is always ready and has no effect.
- Scoreboard clear: a granted write clears busy[addr] at the grant edge, not at the we3 edge.
- Simultaneous set and clear of the same address in one cycle: set wins, so busy stays 1.
- A granted write to a non-busy register is still performed; busy is unchanged.
- hz1 = (chk_a1!=0) & busy[chk_a1] & !(grant this cycle to chk_a1). hz2 is the same for chk_a2. Both are combinational.
- The register file reads old data in the same cycle that we3 writes, so hz must also assert when we3=1 & a3==chk_aX & a3!=0. This covers the registered-write bubble.

Optional Feature:
- Macro: RF_WB_RR_EN.
- Defined: round-robin arbitration. The search starts at the rr pointer. After a grant to g, rr <= (g+1) mod NUM_REQ. rr resets to 0 and is unchanged on idle cycles.
- Undefined: fixed priority as above; no rr register is instantiated.

Test Plan:
- Reset check: assert reset 2 cycles mid-stream (req_valid=3'b111) -> next cycle we3=0, busy=0, req_ready=0 during reset, a3=0, wd3=0.
- Priority: req_valid=3'b110, req0 absent, req1 addr 5 data 0x11, req2 addr 6 data 0x22 -> ready=3'b010 at cycle 0; cycle 1 we3=1 a3=5 wd3=0x11, ready=3'b100; cycle 2 a3=6 wd3=0x22.
- Scoreboard: rsv addr 7 -> busy[7]=1, chk_a1=7 gives hz1=1. Second rsv addr 7 -> rsv_ready=0. Granted write to 7 with rsv addr 7 in the same cycle -> busy[7] stays 1.
- x0 handling: rsv addr 0 -> busy=0. Write req addr 0 data 0xDEAD -> req_ready=1, we3=0 next cycle; chk_a1=0 -> hz1=0.
- Bubble hazard: write to 9 granted at edge N, chk_a2=9 -> hz2=0 in the grant cycle; cycle N+1 (we3=1, a3=9) -> hz2=1; cycle N+2 -> hz2=0.
- RF_WB_RR_EN defined: req_valid=3'b111 held 6 cycles -> grant order 0,1,2,0,1,2. Without the macro the order is 0,1,2 as each requester drops after its grant.
